// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: ROB tag width, datapath width and the broadcast packet
// seen by the ROB, reservation stations and map table.
package cdb_arbiter_pkg;

  localparam int ROB_TAG_BITS = 5;
  localparam int XLEN         = 32;

  typedef struct packed {
    logic                    valid;
    logic [ROB_TAG_BITS-1:0] tag;
    logic [XLEN-1:0]         value;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i (wrapping),
// returned as a one-hot grant plus its index. Also usable for RS issue selection.
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam int PW = IDX_W + 1;

  always_comb begin
    logic [PW-1:0] pos;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      // Extra bit keeps ptr+k from aliasing before the wrap when N is not a power of two
      pos = {1'b0, ptr_i} + PW'(k);
      if (pos >= PW'(N)) begin
        pos = pos - PW'(N);
      end
      if (!any_o && req_i[pos[IDX_W-1:0]]) begin
        any_o                    = 1'b1;
        grant_o[pos[IDX_W-1:0]]  = 1'b1;
        idx_o                    = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with a one-entry holding buffer per FU port; the winner is
// registered onto cdb_* one cycle after capture, losers wait in their buffer.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TAG_BITS = ROB_TAG_BITS
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               squash,
  input  logic [NUM_REQ-1:0]                 fu_valid,
  input  logic [NUM_REQ-1:0][TAG_BITS-1:0]   fu_tag,
  input  logic [NUM_REQ-1:0][XLEN-1:0]       fu_value,
  output logic [NUM_REQ-1:0]                 fu_ready,
  output logic                               cdb_valid,
  output logic [TAG_BITS-1:0]                cdb_tag,
  output logic [XLEN-1:0]                    cdb_value,
  output logic [$clog2(NUM_REQ)-1:0]         cdb_src
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]               buf_vld_q, buf_vld_d;
  logic [NUM_REQ-1:0][TAG_BITS-1:0] buf_tag_q, buf_tag_d;
  logic [NUM_REQ-1:0][XLEN-1:0]     buf_val_q, buf_val_d;
  logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                             cdb_vld_q, cdb_vld_d;
  logic [TAG_BITS-1:0]              cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]                  cdb_val_q, cdb_val_d;
  logic [IDX_W-1:0]                 cdb_src_q, cdb_src_d;

  logic [NUM_REQ-1:0]               cand_vld;
  logic [NUM_REQ-1:0][TAG_BITS-1:0] cand_tag;
  logic [NUM_REQ-1:0][XLEN-1:0]     cand_val;
  logic [NUM_REQ-1:0]               grant;
  logic [IDX_W-1:0]                 win_idx;
  logic                             win_any;

  // A buffered entry always outranks the live input, which the FU holds while not ready
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_vld[i] = buf_vld_q[i] | fu_valid[i];
      cand_tag[i] = buf_vld_q[i] ? buf_tag_q[i] : fu_tag[i];
      cand_val[i] = buf_vld_q[i] ? buf_val_q[i] : fu_value[i];
    end
  end

  rr_priority_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (cand_vld),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  always_comb begin
    buf_vld_d = buf_vld_q;
    buf_tag_d = buf_tag_q;
    buf_val_d = buf_val_q;
    rr_ptr_d  = rr_ptr_q;
    cdb_vld_d = 1'b0;
    cdb_tag_d = cdb_tag_q;
    cdb_val_d = cdb_val_q;
    cdb_src_d = cdb_src_q;
    if (squash) begin
      buf_vld_d = '0;
    end else begin
      if (win_any) begin
        cdb_vld_d = 1'b1;
        cdb_tag_d = cand_tag[win_idx];
        cdb_val_d = cand_val[win_idx];
        cdb_src_d = win_idx;
        rr_ptr_d  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          buf_vld_d[i] = 1'b0;
        end else if (!buf_vld_q[i] && fu_valid[i]) begin
          buf_vld_d[i] = 1'b1;
          buf_tag_d[i] = fu_tag[i];
          buf_val_d[i] = fu_value[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      buf_vld_q <= '0;
      rr_ptr_q  <= '0;
      cdb_vld_q <= 1'b0;
      cdb_tag_q <= '0;
      cdb_val_q <= '0;
      cdb_src_q <= '0;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_tag_q <= buf_tag_d;
      buf_val_q <= buf_val_d;
      rr_ptr_q  <= rr_ptr_d;
      cdb_vld_q <= cdb_vld_d;
      cdb_tag_q <= cdb_tag_d;
      cdb_val_q <= cdb_val_d;
      cdb_src_q <= cdb_src_d;
    end
  end

  assign fu_ready  = ~buf_vld_q;
  assign cdb_valid = cdb_vld_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_val_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expected broadcasts are queued with their due cycle
// when stimulus is driven and checked every cycle by a negedge monitor.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                        clock;
  logic                        reset;
  logic                        squash;
  logic [3:0]                  fu_valid;
  logic [3:0][4:0]             fu_tag;
  logic [3:0][31:0]            fu_value;
  logic [3:0]                  fu_ready;
  logic                        cdb_valid;
  logic [4:0]                  cdb_tag;
  logic [31:0]                 cdb_value;
  logic [1:0]                  cdb_src;

  typedef struct {
    int          cyc;
    logic [4:0]  tag;
    logic [31:0] val;
    logic [1:0]  src;
  } sb_t;

  sb_t sb[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  cdb_arbiter #(.NUM_REQ(4), .TAG_BITS(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_value  (fu_value),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] p, input logic [4:0] t, input logic [31:0] v);
    fu_valid[p] = 1'b1;
    fu_tag[p]   = t;
    fu_value[p] = v;
  endtask

  task automatic idle();
    fu_valid = '0;
  endtask

  task automatic expect_bc(input int d, input logic [4:0] t, input logic [31:0] v,
                           input logic [1:0] s);
    sb.push_back('{cyc + d, t, v, s});
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Every cycle: a broadcast must appear exactly when the head entry is due
  always @(negedge clock) begin
    logic exp_vld;
    sb_t  ent;
    exp_vld = (sb.size() != 0) && (sb[0].cyc == cyc);
    chk("cdb_valid", {63'd0, cdb_valid}, {63'd0, exp_vld});
    if (cdb_valid && exp_vld) begin
      ent = sb.pop_front();
      chk("cdb_tag",   {59'd0, cdb_tag},   {59'd0, ent.tag});
      chk("cdb_value", {32'd0, cdb_value}, {32'd0, ent.val});
      chk("cdb_src",   {62'd0, cdb_src},   {62'd0, ent.src});
    end
  end

  initial begin
    logic [4:0]  ntag;
    logic [31:0] nval;
    logic [3:0]  exp_rdy;
    logic [1:0]  port;

    reset    = 1'b0;
    squash   = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_value = '0;

    // Reset held for two edges
    tick(); tick();
    chk("rst_ready", {60'd0, fu_ready},  64'hF);
    chk("rst_valid", {63'd0, cdb_valid}, 64'h0);
    chk("rst_tag",   {59'd0, cdb_tag},   64'h0);
    chk("rst_value", {32'd0, cdb_value}, 64'h0);
    chk("rst_src",   {62'd0, cdb_src},   64'h0);
    reset = 1'b1;

    // Single requester on port 2
    drive(2'd2, 5'd5, 32'h0000_000A);
    expect_bc(1, 5'd5, 32'h0000_000A, 2'd2);
    tick(); idle();
    chk("single_ready", {60'd0, fu_ready}, 64'hF);
    tick();

    // Lone port 3 request returns rr_ptr to 0
    drive(2'd3, 5'd7, 32'h77);
    expect_bc(1, 5'd7, 32'h77, 2'd3);
    tick(); idle();

    // Four-way contention from rr_ptr 0
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 5'(i + 1), 32'h100 + i);
      expect_bc(i + 1, 5'(i + 1), 32'h100 + i, 2'(i));
    end
    tick(); idle();
    chk("cont_ready1", {60'd0, fu_ready}, 64'h1);
    tick();
    chk("cont_ready2", {60'd0, fu_ready}, 64'h3);
    tick();
    chk("cont_ready3", {60'd0, fu_ready}, 64'h7);
    tick();
    chk("cont_ready4", {60'd0, fu_ready}, 64'hF);

    // Fairness: ports 0 and 1 send whenever they are ready
    ntag = 5'd8;
    nval = 32'hF000;
    for (int k = 0; k < 20; k++) begin
      exp_rdy = (k == 0) ? 4'b1111 : ((k % 2 == 1) ? 4'b1101 : 4'b1110);
      chk("fair_ready", {60'd0, fu_ready}, {60'd0, exp_rdy});
      idle();
      if (k == 0) begin
        drive(2'd0, ntag, nval);
        expect_bc(1, ntag, nval, 2'd0);
        ntag = ntag + 5'd1; nval = nval + 32'd1;
        drive(2'd1, ntag, nval);
        expect_bc(2, ntag, nval, 2'd1);
      end else begin
        port = (k % 2 == 1) ? 2'd0 : 2'd1;
        drive(port, ntag, nval);
        expect_bc(2, ntag, nval, port);
      end
      ntag = ntag + 5'd1; nval = nval + 32'd1;
      tick();
    end
    idle();
    tick();
    chk("fair_drain_ready", {60'd0, fu_ready}, 64'hF);

    // rr_ptr is 1 here; lone port 1 moves it to 2
    drive(2'd1, 5'd19, 32'h1919);
    expect_bc(1, 5'd19, 32'h1919, 2'd1);
    tick(); idle();

    // Ports 1 and 3 lose to port 2 and sit in their buffers, then get squashed
    drive(2'd1, 5'd20, 32'h2020);
    drive(2'd2, 5'd21, 32'h2121);
    drive(2'd3, 5'd22, 32'h2222);
    expect_bc(1, 5'd21, 32'h2121, 2'd2);
    tick(); idle();
    chk("sq_pre_ready", {60'd0, fu_ready}, 64'h5);
    squash = 1'b1;
    drive(2'd0, 5'd9, 32'h0909);
    tick();
    squash = 1'b0;
    idle();
    chk("sq_ready", {60'd0, fu_ready},  64'hF);
    chk("sq_valid", {63'd0, cdb_valid}, 64'h0);
    tick();

    // rr_ptr stayed at 3 through the squash, so port 3 beats port 0
    drive(2'd0, 5'd23, 32'h2323);
    drive(2'd3, 5'd24, 32'h2424);
    expect_bc(1, 5'd24, 32'h2424, 2'd3);
    expect_bc(2, 5'd23, 32'h2323, 2'd0);
    tick(); idle();
    tick(); tick();

    // rr_ptr is 1: port 1 wins, ports 0/2/3 buffered, then reset with squash
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 5'(25 + i), 32'h2500 + i);
    end
    expect_bc(1, 5'd26, 32'h2501, 2'd1);
    tick(); idle();
    chk("rs_pre_ready", {60'd0, fu_ready}, 64'h2);
    reset  = 1'b0;
    squash = 1'b1;
    tick();
    chk("rs_ready", {60'd0, fu_ready},  64'hF);
    chk("rs_valid", {63'd0, cdb_valid}, 64'h0);
    chk("rs_tag",   {59'd0, cdb_tag},   64'h0);
    chk("rs_value", {32'd0, cdb_value}, 64'h0);
    chk("rs_src",   {62'd0, cdb_src},   64'h0);
    reset  = 1'b1;
    squash = 1'b0;

    // Post-reset rr_ptr is 0: port 0 first, then port 3
    drive(2'd0, 5'd29, 32'h2929);
    drive(2'd3, 5'd30, 32'h3030);
    expect_bc(1, 5'd29, 32'h2929, 2'd0);
    expect_bc(2, 5'd30, 32'h3030, 2'd3);
    tick(); idle();
    tick(); tick(); tick();

    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
